// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans eight snapshotted 7-segment patterns onto one shared
// segment bus and a one-hot digit-common bus, one digit per slot, with a
// blanking gap at the start of each slot and mask-selected digit blinking.
module seg_scan_driver #(
  parameter int DIV            = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] SEG0,
  input  logic [7:0] SEG1,
  input  logic [7:0] SEG2,
  input  logic [7:0] SEG3,
  input  logic [7:0] SEG4,
  input  logic [7:0] SEG5,
  input  logic [7:0] SEG6,
  input  logic [7:0] SEG7,
  input  logic [7:0] blink_mask,
  output logic [7:0] seg_out,
  output logic [7:0] com_out,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    SEG_POL   = {8{SEG_ACTIVE_LOW}};
  localparam logic [7:0]    COM_POL   = {8{COM_ACTIVE_LOW}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  // cnt/dig name the slot position that the next edge will present.
  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [FW-1:0] fcnt;
  // ph is the blink phase of the next frame; cur_ph the phase being shown.
  logic          ph;
  logic          cur_ph;
  logic [7:0]    shadow [8];
  logic [7:0]    shadow_mask;
  logic [7:0]    seg_in [8];

  slot_state_t   state;
  slot_state_t   state_next;
  logic          frame_start;
  logic [7:0]    pattern;
  logic          blinked;
  logic [7:0]    seg_next;
  logic [7:0]    com_next;

  // Gather the pattern inputs into an indexable array.
  always_comb begin
    seg_in[0] = SEG0;
    seg_in[1] = SEG1;
    seg_in[2] = SEG2;
    seg_in[3] = SEG3;
    seg_in[4] = SEG4;
    seg_in[5] = SEG5;
    seg_in[6] = SEG6;
    seg_in[7] = SEG7;
  end

  assign frame_start = (cnt == '0) && (dig == 3'd0);

  // Slot-phase decode and logical output values for the next edge; at a frame
  // start the freshly sampled inputs are used so digit 0 needs no extra delay.
  always_comb begin
    state_next = ST_DRIVE;
    seg_next   = 8'h00;
    com_next   = 8'h00;
    pattern    = frame_start ? seg_in[dig] : shadow[dig];
    blinked    = frame_start ? (ph & blink_mask[dig]) : (cur_ph & shadow_mask[dig]);
    if (cnt < BLANK_END) begin
      state_next = ST_BLANK;
    end
    if (state_next == ST_DRIVE) begin
      com_next = 8'b0000_0001 << dig;
      seg_next = blinked ? 8'h00 : pattern;
    end
  end

  // Slot and digit counters; dig wraps 7->0 naturally on its 3-bit width.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      dig <= 3'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      dig <= dig + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame-start snapshot of patterns and mask, plus blink phase bookkeeping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 8'h00;
      end
      shadow_mask <= 8'h00;
      fcnt        <= '0;
      ph          <= 1'b0;
      cur_ph      <= 1'b0;
    end else if (frame_start) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= seg_in[i];
      end
      shadow_mask <= blink_mask;
      cur_ph      <= ph;
      if (fcnt == FCNT_MAX) begin
        fcnt <= '0;
        ph   <= ~ph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Registered slot state and pin-polarity outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_BLANK;
      seg_out    <= SEG_POL;
      com_out    <= COM_POL;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      seg_out    <= seg_next ^ SEG_POL;
      com_out    <= com_next ^ COM_POL;
      frame_tick <= frame_start;
    end
  end

  // The slot state is only observed through the outputs; keep it referenced.
  logic unused_state;
  assign unused_state = (state == ST_DRIVE);

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver with a small
// scan geometry, two polarity variants, a reference model, and vector table.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int BF    = 2;
  localparam int FRAME = 8 * DIV;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] seg_in [8];
  logic [7:0] mask;
  logic [7:0] seg_out, com_out, seg_out_p, com_out_p;
  logic       tick, tick_p;

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [7:0] snap [8];
  logic [7:0] snap_mask;
  logic [7:0] exp_seg, exp_com;
  logic       exp_tick;

  typedef struct {
    int         k;
    logic [7:0] seg;
    logic [7:0] com;
    logic       tick;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF),
                    .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .nrst(nrst),
    .SEG0(seg_in[0]), .SEG1(seg_in[1]), .SEG2(seg_in[2]), .SEG3(seg_in[3]),
    .SEG4(seg_in[4]), .SEG5(seg_in[5]), .SEG6(seg_in[6]), .SEG7(seg_in[7]),
    .blink_mask(mask), .seg_out(seg_out), .com_out(com_out), .frame_tick(tick)
  );

  seg_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF),
                    .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b0)) dut_pol (
    .clk(clk), .nrst(nrst),
    .SEG0(seg_in[0]), .SEG1(seg_in[1]), .SEG2(seg_in[2]), .SEG3(seg_in[3]),
    .SEG4(seg_in[4]), .SEG5(seg_in[5]), .SEG6(seg_in[6]), .SEG7(seg_in[7]),
    .blink_mask(mask), .seg_out(seg_out_p), .com_out(com_out_p), .frame_tick(tick_p)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h (k=%0d, time %0t)", name, act, exp, k, $time);
    end
  endtask

  // Behavioural model: works from the edge index alone (frame, slot, position).
  task automatic modelEdge();
    int t, frame, slot, pos, phase;
    if (!nrst) begin
      k = 0;
      exp_seg = 8'h00;
      exp_com = 8'h00;
      exp_tick = 1'b0;
      return;
    end
    k++;
    t = k - 1;
    if (t % FRAME == 0) begin
      for (int i = 0; i < 8; i++) snap[i] = seg_in[i];
      snap_mask = mask;
    end
    frame = t / FRAME;
    slot  = (t / DIV) % 8;
    pos   = t % DIV;
    phase = (frame / BF) % 2;
    exp_tick = (t % FRAME == 0);
    if (pos < BLANK) begin
      exp_seg = 8'h00;
      exp_com = 8'h00;
    end else begin
      exp_com = 8'(1 << slot);
      exp_seg = (phase == 1 && snap_mask[slot]) ? 8'h00 : snap[slot];
    end
  endtask

  task automatic checkAll();
    checkOutput("seg", seg_out, exp_seg);
    checkOutput("com", com_out, ~exp_com);
    checkOutput("tick", {7'b0, tick}, {7'b0, exp_tick});
    checkOutput("seg_pol", seg_out_p, ~exp_seg);
    checkOutput("com_pol", com_out_p, exp_com);
    checkOutput("tick_pol", {7'b0, tick_p}, {7'b0, exp_tick});
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic runTo(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 2000) begin
      applyStimulus();
      guard++;
    end
    checkOutput("run_to_k", 8'(k), 8'(target));
  endtask

  task automatic setPatterns();
    for (int i = 0; i < 8; i++) seg_in[i] = 8'h10 + 8'(i);
  endtask

  task automatic doReset();
    @(negedge clk);
    nrst = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  task automatic handCheck(input string name, input logic [7:0] s, input logic [7:0] c);
    checkOutput({name, "_seg"}, seg_out, s);
    checkOutput({name, "_com"}, com_out, c);
  endtask

  initial begin
    vecs[0] = '{1,  8'h00, 8'hFF, 1'b1};
    vecs[1] = '{2,  8'h10, 8'hFE, 1'b0};
    vecs[2] = '{4,  8'h10, 8'hFE, 1'b0};
    vecs[3] = '{5,  8'h00, 8'hFF, 1'b0};
    vecs[4] = '{6,  8'h11, 8'hFD, 1'b0};
    vecs[5] = '{16, 8'h13, 8'hF7, 1'b0};
    vecs[6] = '{29, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{32, 8'h17, 8'h7F, 1'b0};
    vecs[8] = '{33, 8'h00, 8'hFF, 1'b1};
    vecs[9] = '{34, 8'h10, 8'hFE, 1'b0};

    // Reset held with random patterns.
    for (int i = 0; i < 8; i++) seg_in[i] = 8'($urandom);
    mask = 8'($urandom);
    doReset();
    handCheck("reset", 8'h00, 8'hFF);
    checkOutput("reset_tick", {7'b0, tick}, 8'h00);
    checkOutput("reset_seg_pol", seg_out_p, 8'hFF);
    checkOutput("reset_com_pol", com_out_p, 8'h00);

    // Scan order against the hand-computed vector table.
    setPatterns();
    mask = 8'h00;
    nrst = 1'b1;
    for (int v = 0; v < 10; v++) begin
      runTo(vecs[v].k);
      handCheck($sformatf("vec%0d", v), vecs[v].seg, vecs[v].com);
      checkOutput($sformatf("vec%0d_tick", v), {7'b0, tick}, {7'b0, vecs[v].tick});
    end

    // Tear-free snapshot and polarity of an 8'h81 pattern.
    doReset();
    setPatterns();
    seg_in[0] = 8'h81;
    seg_in[3] = 8'h3F;
    nrst = 1'b1;
    runTo(2);
    checkOutput("pol_seg", seg_out_p, 8'h7E);
    checkOutput("pol_com", com_out_p, 8'h01);
    runTo(6);
    seg_in[3] = 8'h06;
    runTo(14);
    handCheck("tear_f0", 8'h3F, 8'hF7);
    runTo(46);
    handCheck("tear_f1", 8'h06, 8'hF7);

    // Blink with mask 8'h05 over five frames.
    doReset();
    setPatterns();
    mask = 8'h05;
    nrst = 1'b1;
    runTo(2);
    handCheck("blink_f0_d0", 8'h10, 8'hFE);
    runTo(66);
    handCheck("blink_f2_d0", 8'h00, 8'hFE);
    runTo(70);
    handCheck("blink_f2_d1", 8'h11, 8'hFD);
    runTo(74);
    handCheck("blink_f2_d2", 8'h00, 8'hFB);
    runTo(98);
    handCheck("blink_f3_d0", 8'h00, 8'hFE);
    runTo(130);
    handCheck("blink_f4_d0", 8'h10, 8'hFE);

    // Random inputs, asynchronous reset during digit 5 DRIVE, then long random run.
    doReset();
    nrst = 1'b1;
    for (int i = 0; i < 23; i++) begin
      for (int j = 0; j < 8; j++) seg_in[j] = 8'($urandom);
      mask = 8'($urandom);
      applyStimulus();
    end
    #2;
    nrst = 1'b0;
    #1;
    handCheck("async_reset", 8'h00, 8'hFF);
    checkOutput("async_reset_tick", {7'b0, tick}, 8'h00);
    checkOutput("async_reset_seg_pol", seg_out_p, 8'hFF);
    applyStimulus();
    nrst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 8; j++) seg_in[j] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 8-digit 7-segment display scanner: the physical-display end of the game's SEG0..SEG7 pattern bus. Once per frame it snapshots eight 8-bit segment patterns, then drives one shared segment bus and a one-hot digit-common bus, one digit at a time. It inserts a blanking gap between digits to suppress ghosting, and blinks digits selected by a mask. It sits between the game top level and the board pins.

## Interface
- DIV, 1000: clk cycles per digit slot; DIV ≥ 2.
- BLANK_CYCLES, 16: blanked cycles at the start of each slot; 0 ≤ BLANK_CYCLES < DIV.
- BLINK_FRAMES, 64: frames per blink half-period; ≥ 1.
- SEG_ACTIVE_LOW, 0: 1 = seg_out bit low means lit.
- COM_ACTIVE_LOW, 1: 1 = com_out bit low means digit selected.

- clk  in  1  clock.
- nrst  in  1  reset; asynchronous, active-low.
- SEG0..SEG7  in  8 each  segment patterns; bit = 1 means lit; SEGn shown on digit n.
- blink_mask  in  8  bit n = 1 blinks digit n.
- seg_out  out  8  shared segment bus, polarity per SEG_ACTIVE_LOW.
- com_out  out  8  one-hot digit select, polarity per COM_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse at each frame start.

## Operation
- Reset is decided as stated: nrst asynchronous, active-low; clk is the clock.
- State:
  - slot counter cnt, 0..DIV-1, width $clog2(DIV);
  - digit counter dig, 0..7;
  - frame counter fcnt, 0..BLINK_FRAMES-1;
  - blink phase bit ph;
  - shadow[0..7] (8 bits each) and shadow_mask (8 bits).
- Counting: cnt increments every cycle.
  - When cnt wraps DIV-1→0, dig increments, 7→0.
  - When dig wraps to 0, a new frame starts.
- Snapshot: at each frame start, SEG0..SEG7 are captured into shadow and blink_mask into shadow_mask. Input changes within a frame are invisible until the next frame (tear-free).
- Blink: fcnt increments at each frame start.
  - When fcnt wraps BLINK_FRAMES-1→0, ph toggles.
  - While ph = 1, digits whose shadow_mask bit is 1 display pattern 0 (all off); com_out still selects them.
- Slot phases (two-state FSM per slot):
  - BLANK for cnt < BLANK_CYCLES: com_out all inactive, seg_out all off.
  - DRIVE for the remaining cycles: com_out selects only digit dig; seg_out = shadow[dig], or 0 if blinked.
- Polarity:
  - Logical lit/selected = 1 internally.
  - seg_out = logical ^ {8{SEG_ACTIVE_LOW}}.
  - com_out = logical ^ {8{COM_ACTIVE_LOW}}.
- Invariant: com_out never selects more than one digit in any cycle.

## Timing
- Reset values (nrst low), with defaults:
  - cnt = 0, dig = 0, fcnt = 0, ph = 0, shadow = 0, shadow_mask = 0.
  - seg_out = 8'h00 (all off).
  - com_out = 8'hFF (none selected).
  - frame_tick = 0.
- Timeline: let edge k ≥ 1 be the k-th rising clk after nrst deasserts, and t = k−1.
  - Outputs are registered and reflect slot = (t / DIV) mod 8 and pos = t mod DIV.
- Frame start: at an edge with t mod (8·DIV) = 0:
  - snapshot is sampled at that edge;
  - frame_tick is high for exactly the following cycle;
  - the first frame starts at edge 1.
- DRIVE output of a digit is valid starting at the edge with pos = BLANK_CYCLES.
- With BLANK_CYCLES = 0, slots are back-to-back with no gap. The digit change still occurs on a single edge.
- ph toggles at the frame start following BLINK_FRAMES complete frames. The first toggle occurs at the start of frame BLINK_FRAMES.
- Reset mid-operation:
  - All outputs are forced to reset values immediately (asynchronously).
  - Scanning restarts at frame 0, digit 0, with a fresh snapshot at edge 1.
- Input setup: SEGn and blink_mask are sampled only at frame-start edges; they may change on any other cycle without effect.

## Test plan
- Reset: hold nrst low with random SEG inputs -> seg_out = 8'h00, com_out = 8'hFF, frame_tick = 0. Release -> frame_tick = 1 after edge 1, then 0 after edge 2.
- Scan order (DIV=4, BLANK_CYCLES=1, SEGn = 8'h10+n):
  - each 4-cycle slot gives 1 cycle com_out = FF / seg_out = 00;
  - then 3 cycles com_out = ~(1<<n), seg_out = 8'h10+n;
  - order n = 0..7, repeating every 32 cycles.
- Tear-free: change SEG3 from 8'h3F to 8'h06 during digit 1 of frame 0 -> digit 3 shows 8'h3F in frame 0 and 8'h06 from frame 1.
- Blink (BLINK_FRAMES=2, blink_mask = 8'h05):
  - frames 0–1: digits 0 and 2 show their patterns;
  - frames 2–3: digits 0 and 2 show seg_out = 00 while still selected; other digits are unaffected;
  - frame 4: the patterns return.
- Reset mid-scan: assert nrst during digit 5, DRIVE -> outputs go to reset values without waiting for a clk edge. After release -> scanning restarts at digit 0 with a new snapshot.
- Polarity: SEG_ACTIVE_LOW=1, COM_ACTIVE_LOW=0, SEG0 = 8'h81 -> reset gives seg_out = FF, com_out = 00. Digit 0 DRIVE gives seg_out = 8'h7E, com_out = 8'h01.
